// File: rtl/shared_mem_pkg.sv
// shared_mem_pkg: request record and arbiter FSM states shared by the memory arbiter.
package shared_mem_pkg;
  typedef struct packed {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    // scanning from the far end lets the closest requester overwrite earlier picks
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin sharing of one single-port data memory among cores,
// one transaction at a time, with a one-cycle response pulse to the winner.
module shared_mem_arbiter
  import shared_mem_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int MEM_AW    = 10,
  parameter int MEM_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CORES-1:0]    req_valid,
  input  logic [NUM_CORES-1:0]    req_we,
  input  logic [NUM_CORES*4-1:0]  req_mask,
  input  logic [NUM_CORES*32-1:0] req_addr,
  input  logic [NUM_CORES*32-1:0] req_wdata,
  output logic [NUM_CORES-1:0]    req_ready,
  output logic [NUM_CORES-1:0]    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [3:0]              mem_mask,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  arb_state_e state, state_n;
  logic [IW-1:0] rr_ptr, g, gnt_idx;
  logic [NUM_CORES-1:0] gnt;
  logic [CW-1:0] cnt;
  logic [31:0] rdata_q;
  mem_req_t req_q, sel;
  logic unused_addr;
  rr_arbiter #(.N(NUM_CORES)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  assign sel = '{
    we:    req_we[gnt_idx],
    mask:  req_mask[4*gnt_idx +: 4],
    addr:  req_addr[32*gnt_idx +: 32],
    wdata: req_wdata[32*gnt_idx +: 32]
  };
  always_comb begin
    state_n = state == IDLE   ? (|req_valid ? ACCESS : IDLE) :
              state == ACCESS ? WAIT :
              state == WAIT   ? (cnt == '0 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      g       <= '0;
      req_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req_valid) begin
        g     <= gnt_idx;
        req_q <= sel;
      end
      if (state == ACCESS) cnt <= CW'(MEM_LAT - 1);
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) rdata_q <= req_q.we ? '0 : mem_rdata;
      end
      if (state == RESP) rr_ptr <= (g == IW'(NUM_CORES - 1)) ? '0 : g + 1'b1;
    end
  end
  // grant is combinational off req_valid, so it must also be silenced while reset is held
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign rsp_valid = state == RESP ? NUM_CORES'(1) << g : '0;
  assign rsp_rdata = state == RESP ? rdata_q : '0;
  assign mem_en    = state == ACCESS;
  assign mem_we    = mem_en & req_q.we;
  assign mem_mask  = mem_en ? req_q.mask : '0;
  assign mem_addr  = mem_en ? req_q.addr[MEM_AW+1:2] : '0;
  assign mem_wdata = mem_en ? req_q.wdata : '0;
  assign unused_addr = ^{req_q.addr[31:MEM_AW+2], req_q.addr[1:0]};
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: scoreboard bench with a 2-core/latency-1 and a 3-core/latency-3 arbiter.
module tb_shared_mem_arbiter;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  typedef struct {int core; logic [31:0] data; int cyc;} rsp_t;
  typedef struct {int core; int cyc;} gnt_t;
  rsp_t qa[$], qb[$];
  gnt_t ga[$], gb[$];
  rsp_t ea, eb;
  logic [1:0]  va = 0, wea = 0, ready_a, rsp_valid_a;
  logic [7:0]  ma = 0;
  logic [63:0] aa = 0, wa = 0;
  logic [31:0] rsp_rdata_a, mem_wdata_a, rd_a;
  logic        mem_en_a, mem_we_a;
  logic [3:0]  mem_mask_a;
  logic [9:0]  mem_addr_a;
  logic [31:0] mem_a [16];
  shared_mem_arbiter #(.NUM_CORES(2), .MEM_AW(10), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_we(wea), .req_mask(ma), .req_addr(aa),
    .req_wdata(wa), .req_ready(ready_a), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_mask(mem_mask_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(rd_a)
  );
  always @(posedge clk) if (mem_en_a) begin
    rd_a <= mem_a[mem_addr_a[3:0]];
    if (mem_we_a) for (int b = 0; b < 4; b++)
      if (mem_mask_a[b]) mem_a[mem_addr_a[3:0]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
  end
  logic [2:0]  vb = 0, ready_b, rsp_valid_b;
  logic [95:0] ab = {32'h8, 32'h4, 32'h0};
  logic [31:0] rsp_rdata_b, mem_wdata_b, p1, p2, p3;
  logic        mem_en_b, mem_we_b;
  logic [3:0]  mem_mask_b;
  logic [9:0]  mem_addr_b;
  logic [31:0] mem_b [4];
  shared_mem_arbiter #(.NUM_CORES(3), .MEM_AW(10), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_we(3'b000), .req_mask(12'hfff), .req_addr(ab),
    .req_wdata(96'h0), .req_ready(ready_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_mask(mem_mask_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(p3)
  );
  always @(posedge clk) begin
    if (mem_en_b) p1 <= mem_b[mem_addr_b[1:0]];
    p2 <= p1;
    p3 <= p2;
  end
  function automatic int idx(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (ready_a != 0) begin
      chk("ready_onehot_a", 32'($onehot(ready_a)), 1);
      ga.push_back('{idx({1'b0, ready_a}), cyc});
    end
    if (rsp_valid_a != 0) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_a_unexpected: actual core %0d required none", idx({1'b0, rsp_valid_a}));
      end else begin
        ea = qa.pop_front();
        chk("rsp_a_core", idx({1'b0, rsp_valid_a}), ea.core);
        chk("rsp_a_onehot", 32'($onehot(rsp_valid_a)), 1);
        chk("rsp_a_data", rsp_rdata_a, ea.data);
        chk("rsp_a_cycle", cyc, ea.cyc);
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    if (ready_b != 0) begin
      chk("ready_onehot_b", 32'($onehot(ready_b)), 1);
      gb.push_back('{idx(ready_b), cyc});
    end
    if (rsp_valid_b != 0) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_b_unexpected: actual core %0d required none", idx(rsp_valid_b));
      end else begin
        eb = qb.pop_front();
        chk("rsp_b_core", idx(rsp_valid_b), eb.core);
        chk("rsp_b_data", rsp_rdata_b, eb.data);
        chk("rsp_b_cycle", cyc, eb.cyc);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drain;
    for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk("drain_empty", qa.size() + qb.size(), 0);
  endtask
  task automatic exp_gnt(input bit side_b, input int core, input int c);
    gnt_t g;
    if ((side_b ? gb.size() : ga.size()) == 0) begin
      n_chk++; n_fail++;
      $display("FAIL gnt_%s_missing: actual none required core %0d", side_b ? "b" : "a", core);
    end else begin
      g = side_b ? gb.pop_front() : ga.pop_front();
      chk(side_b ? "gnt_b_core" : "gnt_a_core", g.core, core);
      chk(side_b ? "gnt_b_cycle" : "gnt_a_cycle", g.cyc, c);
    end
  endtask
  int t, r;
  initial begin
    for (int i = 0; i < 16; i++) mem_a[i] = 32'h0;
    mem_a[2] = 32'h11223344;
    mem_a[4] = 32'hDEADBEEF;
    mem_a[5] = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) mem_b[i] = 32'hB0000000 | i;
    #1 rst = 1;
    va = 2'b11;
    vb = 3'b111;
    #1;
    chk("rst_ready_a", ready_a, 0);
    chk("rst_ready_b", ready_b, 0);
    chk("rst_mem_en_a", mem_en_a, 0);
    chk("rst_rsp_valid_a", rsp_valid_a, 0);
    chk("rst_rsp_rdata_a", rsp_rdata_a, 0);
    chk("rst_mem_addr_a", mem_addr_a, 0);
    va = 0;
    vb = 0;
    repeat (2) tick();
    rst = 0;
    // core0 load from word 4
    tick();
    va = 2'b01; aa[31:0] = 32'h10; t = cyc;
    qa.push_back('{0, 32'hDEADBEEF, t + 3});
    @(negedge clk) chk("t1_ready", ready_a, 2'b01);
    tick();
    va = 0;
    @(negedge clk);
    chk("t1_mem_en", mem_en_a, 1);
    chk("t1_mem_addr", mem_addr_a, 4);
    chk("t1_mem_we", mem_we_a, 0);
    tick();
    @(negedge clk);
    chk("t1_mem_en_off", mem_en_a, 0);
    chk("t1_mem_addr_off", mem_addr_a, 0);
    drain();
    exp_gnt(0, 0, t);
    // core1 masked store to word 2
    tick();
    va = 2'b10; wea = 2'b10; ma = 8'h30; aa[63:32] = 32'h8; wa[63:32] = 32'hAABBCCDD; t = cyc;
    qa.push_back('{1, 32'h0, t + 3});
    @(negedge clk) chk("t2_ready", ready_a, 2'b10);
    tick();
    va = 0; wea = 0;
    @(negedge clk);
    chk("t2_mem_en", mem_en_a, 1);
    chk("t2_mem_we", mem_we_a, 1);
    chk("t2_mem_mask", mem_mask_a, 4'b0011);
    chk("t2_mem_addr", mem_addr_a, 2);
    chk("t2_mem_wdata", mem_wdata_a, 32'hAABBCCDD);
    drain();
    chk("t2_mem_word", mem_a[2], 32'h1122CCDD);
    exp_gnt(0, 1, t);
    // both cores continuously from reset; core1 address has junk in ignored bits
    aa = {32'hFFFFF017, 32'h10};
    rst = 1; va = 2'b11;
    repeat (2) tick();
    rst = 0; r = cyc;
    for (int i = 0; i < 4; i++)
      qa.push_back('{i % 2, (i % 2) ? 32'h55AA55AA : 32'hDEADBEEF, r + 4*i + 3});
    repeat (13) tick();
    va = 0;
    drain();
    for (int i = 0; i < 4; i++) exp_gnt(0, i % 2, r + 4*i);
    // core1 pulses valid during core0's access; pointer must then favour core1
    tick();
    va = 2'b01; t = cyc;
    qa.push_back('{0, 32'hDEADBEEF, t + 3});
    tick(); va = 2'b10;
    tick(); va = 2'b00;
    repeat (3) tick();
    va = 2'b11; r = cyc;
    qa.push_back('{1, 32'h55AA55AA, r + 3});
    @(negedge clk) chk("t6_ready", ready_a, 2'b10);
    tick();
    va = 0;
    drain();
    exp_gnt(0, 0, t);
    exp_gnt(0, 1, r);
    // three cores, latency 3: wrap then lone core2 with pointer at 1
    rst = 1; vb = 3'b111;
    repeat (2) tick();
    rst = 0; r = cyc;
    for (int i = 0; i < 4; i++)
      qb.push_back('{i % 3, 32'hB0000000 | (i % 3), r + 6*i + 5});
    repeat (19) tick();
    vb = 3'b100;
    qb.push_back('{2, 32'hB0000002, r + 29});
    repeat (6) tick();
    vb = 0;
    drain();
    for (int i = 0; i < 4; i++) exp_gnt(1, i % 3, r + 6*i);
    exp_gnt(1, 2, r + 24);
    // reset during the latency wait aborts the transaction silently
    tick();
    vb = 3'b010; t = cyc;
    tick(); vb = 0;
    repeat (2) tick();
    rst = 1; vb = 3'b111; va = 2'b11;
    #1;
    chk("t5_mem_en_b", mem_en_b, 0);
    chk("t5_rsp_valid_b", rsp_valid_b, 0);
    chk("t5_ready_b", ready_b, 0);
    chk("t5_ready_a", ready_a, 0);
    va = 0;
    repeat (2) tick();
    rst = 0; r = cyc;
    qb.push_back('{0, 32'hB0000000, r + 5});
    tick();
    vb = 0;
    drain();
    exp_gnt(1, 1, t);
    exp_gnt(1, 0, r);
    repeat (10) tick();
    chk("no_stray_grants", ga.size() + gb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
